// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared state encoding and latency constant for the divide controller
package md_pkg;

  // Controller states: waiting, divider running, result buffered, draining a cancelled op
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } div_state_e;

  // Cycles from div_en to div_finish of the EX-stage divider
  localparam int DIV_LAT = 17;

endpackage

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - launches DIV/DIVU, stalls EX, buffers Q/R and writes HI/LO
module div_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_sign,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        ex_allowout,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_en,
  output logic        div_sign,
  output logic        div_cancel,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_working,
  input  logic        div_finish
);

  div_state_e  state_q, state_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  // Operands always follow EX; div_en alone decides whether the divider takes them
  assign div_a    = req_a;
  assign div_b    = req_b;
  assign div_sign = req_sign;

  // Next state, result capture and all combinational control outputs
  always_comb begin
    state_d    = state_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    stall      = 1'b0;
    hilo_we    = 1'b0;
    div_en     = 1'b0;
    div_cancel = 1'b0;
    hi_wdata   = res_hi_q;
    lo_wdata   = res_lo_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (div_working) begin
            // Divider still busy with an op we no longer own (e.g. after reset)
            stall = 1'b1;
          end else if (!flush) begin
            div_en  = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (div_finish) begin
          // Result bypasses straight from the divider in its finish cycle
          hi_wdata = div_r;
          lo_wdata = div_q;
          if (flush) begin
            state_d = IDLE;
          end else if (ex_allowout) begin
            hilo_we = 1'b1;
            state_d = IDLE;
          end else begin
            res_hi_d = div_r;
            res_lo_d = div_q;
            state_d  = DONE;
          end
        end else begin
          stall = 1'b1;
          if (flush) begin
            div_cancel = 1'b1;
            state_d    = DRAIN;
          end
        end
      end

      DONE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (ex_allowout) begin
          hilo_we = 1'b1;
          state_d = IDLE;
        end
      end

      DRAIN: begin
        // The cancelled op still finishes once; swallow that finish
        stall = req;
        if (div_finish) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl with a behavioural divider
module tb_div_ctrl;
  import md_pkg::DIV_LAT;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_sign;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        ex_allowout;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_en;
  logic        div_sign;
  logic        div_cancel;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_working;
  logic        div_finish;

  int total = 0;
  int bad   = 0;
  int n_writes = 0;
  int n_launch = 0;

  div_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .req_sign(req_sign),
    .req_a(req_a), .req_b(req_b), .flush(flush), .ex_allowout(ex_allowout),
    .stall(stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .div_en(div_en), .div_sign(div_sign), .div_cancel(div_cancel),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .div_working(div_working), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  // Architectural result: {HI=remainder, LO=quotient}, C-style truncation
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Divider environment: fixed latency, ignores cancel (the op runs to completion), not reset by core reset
  logic        dv_busy = 1'b0;
  int          dv_cnt  = 0;
  logic [63:0] dv_res  = 64'd0;
  assign div_working = dv_busy;
  assign div_finish  = dv_busy && (dv_cnt == DIV_LAT);
  assign div_q       = dv_res[31:0];
  assign div_r       = dv_res[63:32];

  always @(posedge clk) begin
    if (dv_busy) begin
      if (dv_cnt == DIV_LAT) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt + 1;
    end else if (div_en) begin
      dv_busy <= 1'b1;
      dv_cnt  <= 1;
      dv_res  <= ref_div(div_sign, div_a, div_b);
    end
  end

  // Transaction model: whether the controller owns an op, whether it was cancelled, whether a result is held
  logic        m_owned = 1'b0;
  logic        m_cancelled = 1'b0;
  logic        m_held = 1'b0;
  logic [63:0] m_res = 64'd0;

  always @(negedge clk) begin
    logic e_launch, e_stall, e_we, e_cancel, fin;
    chk("div_a_follow", div_a, req_a);
    chk("div_b_follow", div_b, req_b);
    chk("div_sign_follow", {31'd0, div_sign}, {31'd0, req_sign});
    if (reset) begin
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_hilo_we", {31'd0, hilo_we}, 32'd0);
      chk("rst_div_en", {31'd0, div_en}, 32'd0);
      chk("rst_cancel", {31'd0, div_cancel}, 32'd0);
      chk("rst_hi", hi_wdata, 32'd0);
      chk("rst_lo", lo_wdata, 32'd0);
      m_owned = 1'b0; m_cancelled = 1'b0; m_held = 1'b0;
    end else begin
      fin = div_finish;
      e_launch = !m_owned && req && !flush && !div_working;
      if (!m_owned)               e_stall = req && (div_working || !flush);
      else if (m_cancelled)       e_stall = req;
      else if (m_held || fin)     e_stall = 1'b0;
      else                        e_stall = 1'b1;
      e_we     = m_owned && !m_cancelled && (m_held || fin) && ex_allowout && !flush;
      e_cancel = m_owned && !m_cancelled && !m_held && !fin && flush;
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("div_en", {31'd0, div_en}, {31'd0, e_launch});
      chk("hilo_we", {31'd0, hilo_we}, {31'd0, e_we});
      chk("div_cancel", {31'd0, div_cancel}, {31'd0, e_cancel});
      if (m_owned && !m_cancelled && (m_held || fin)) begin
        chk("hi_wdata", hi_wdata, m_res[63:32]);
        chk("lo_wdata", lo_wdata, m_res[31:0]);
      end
      if (hilo_we) n_writes++;
      if (div_en) n_launch++;
      if (e_launch) begin
        m_owned = 1'b1;
        m_res   = ref_div(req_sign, req_a, req_b);
      end else if (m_owned) begin
        if (m_cancelled) begin
          if (fin) begin m_owned = 1'b0; m_cancelled = 1'b0; end
        end else if (m_held || fin) begin
          if (flush || ex_allowout) begin m_owned = 1'b0; m_held = 1'b0; end
          else m_held = 1'b1;
        end else if (flush) begin
          m_cancelled = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic s, input logic [31:0] a, input logic [31:0] b);
    req = r; req_sign = s; req_a = a; req_b = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, l0;
    reset = 1'b1; flush = 1'b0; ex_allowout = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Signed divide, EX advances immediately
    w0 = n_writes;
    for (int k = 0; k <= 17; k++) begin
      if (k == 0) begin set_req(1'b1, 1'b1, -32'sd7, 32'd2); ex_allowout = 1'b1; end
      @(negedge clk);
      if (k == 0) chk("t1_div_en_c0", {31'd0, div_en}, 32'd1);
      if (k <= 16) chk("t1_stall", {31'd0, stall}, 32'd1);
      if (k == 17) begin
        chk("t1_we_c17", {31'd0, hilo_we}, 32'd1);
        chk("t1_lo", lo_wdata, 32'hFFFF_FFFD);
        chk("t1_hi", hi_wdata, 32'hFFFF_FFFF);
      end
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    tick();
    chk("t1_writes", n_writes - w0, 32'd1);

    // Unsigned divide, EX held until cycle 22
    w0 = n_writes; l0 = n_launch;
    for (int k = 0; k <= 22; k++) begin
      if (k == 0) set_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd16);
      if (k == 22) ex_allowout = 1'b1;
      @(negedge clk);
      if (k == 17) begin
        chk("t2_stall_c17", {31'd0, stall}, 32'd0);
        chk("t2_lo_bypass", lo_wdata, 32'h0FFF_FFFF);
      end
      if (k == 20) begin
        chk("t2_done_lo", lo_wdata, 32'h0FFF_FFFF);
        chk("t2_done_hi", hi_wdata, 32'h0000_000F);
        chk("t2_done_stall", {31'd0, stall}, 32'd0);
      end
      if (k == 22) chk("t2_we_c22", {31'd0, hilo_we}, 32'd1);
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    tick();
    chk("t2_writes", n_writes - w0, 32'd1);
    chk("t2_launches", n_launch - l0, 32'd1);

    // Flush mid-run, then a new request waits out the drain
    w0 = n_writes;
    for (int k = 0; k <= 35; k++) begin
      if (k == 0) begin set_req(1'b1, 1'b1, 32'd100, 32'd7); ex_allowout = 1'b1; end
      if (k == 5) flush = 1'b1;
      if (k == 6) begin flush = 1'b0; req = 1'b0; end
      if (k == 8) set_req(1'b1, 1'b0, 32'd1000, 32'd10);
      @(negedge clk);
      if (k == 5) chk("t3_cancel_c5", {31'd0, div_cancel}, 32'd1);
      if (k == 10) chk("t3_drain_stall", {31'd0, stall}, 32'd1);
      if (k == 17) chk("t3_finish_discard", {31'd0, hilo_we}, 32'd0);
      if (k == 18) chk("t3_relaunch_c18", {31'd0, div_en}, 32'd1);
      if (k == 35) begin
        chk("t3_we_c35", {31'd0, hilo_we}, 32'd1);
        chk("t3_lo", lo_wdata, 32'd100);
        chk("t3_hi", hi_wdata, 32'd0);
      end
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    tick();
    chk("t3_writes", n_writes - w0, 32'd1);

    // Flush coincident with finish
    w0 = n_writes;
    for (int k = 0; k <= 35; k++) begin
      if (k == 0) begin set_req(1'b1, 1'b1, -32'sd100, 32'd3); ex_allowout = 1'b1; end
      if (k == 17) flush = 1'b1;
      if (k == 18) begin flush = 1'b0; set_req(1'b1, 1'b0, 32'd7, 32'd3); end
      @(negedge clk);
      if (k == 17) begin
        chk("t4_no_cancel", {31'd0, div_cancel}, 32'd0);
        chk("t4_no_we", {31'd0, hilo_we}, 32'd0);
      end
      if (k == 18) chk("t4_idle_launch", {31'd0, div_en}, 32'd1);
      if (k == 35) begin
        chk("t4_lo", lo_wdata, 32'd2);
        chk("t4_hi", hi_wdata, 32'd1);
      end
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    tick();
    chk("t4_writes", n_writes - w0, 32'd1);

    // Reset mid-run while the divider is working
    w0 = n_writes;
    for (int k = 0; k <= 35; k++) begin
      if (k == 0) begin set_req(1'b1, 1'b0, 32'd50, 32'd5); ex_allowout = 1'b1; end
      if (k == 8) begin reset = 1'b1; req = 1'b0; end
      if (k == 9) begin reset = 1'b0; set_req(1'b1, 1'b1, 32'd9, -32'sd4); end
      @(negedge clk);
      if (k == 8) begin
        chk("t5_rst_stall", {31'd0, stall}, 32'd0);
        chk("t5_rst_lo", lo_wdata, 32'd0);
        chk("t5_working", {31'd0, div_working}, 32'd1);
      end
      if (k == 12) chk("t5_guard_stall", {31'd0, stall}, 32'd1);
      if (k == 17) chk("t5_guard_no_en", {31'd0, div_en}, 32'd0);
      if (k == 18) chk("t5_launch_c18", {31'd0, div_en}, 32'd1);
      if (k == 35) begin
        chk("t5_we", {31'd0, hilo_we}, 32'd1);
        chk("t5_lo", lo_wdata, 32'hFFFF_FFFE);
        chk("t5_hi", hi_wdata, 32'd1);
      end
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    tick();
    chk("t5_writes", n_writes - w0, 32'd1);

    // Back-to-back divides
    w0 = n_writes; l0 = n_launch;
    for (int k = 0; k <= 35; k++) begin
      if (k == 0) begin set_req(1'b1, 1'b1, 32'd20, 32'd6); ex_allowout = 1'b1; end
      if (k == 18) set_req(1'b1, 1'b1, -32'sd20, -32'sd6);
      @(negedge clk);
      if (k == 17) begin
        chk("t6_we1", {31'd0, hilo_we}, 32'd1);
        chk("t6_lo1", lo_wdata, 32'd3);
        chk("t6_hi1", hi_wdata, 32'd2);
      end
      if (k == 18) chk("t6_en2_c18", {31'd0, div_en}, 32'd1);
      if (k == 35) begin
        chk("t6_we2", {31'd0, hilo_we}, 32'd1);
        chk("t6_lo2", lo_wdata, 32'd3);
        chk("t6_hi2", hi_wdata, 32'hFFFF_FFFE);
      end
      tick();
    end
    req = 1'b0; ex_allowout = 1'b0;
    repeat (2) tick();
    chk("t6_writes", n_writes - w0, 32'd2);
    chk("t6_launches", n_launch - l0, 32'd2);
    chk("end_idle", {31'd0, m_owned}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
